// File: rtl/layer_pkg.sv
// ----------------------------------------------------------------------------
// layer_pkg
//   Shared definitions for the SPI-to-layer pixel sequencer:
//     - SPI command bytes
//     - RAM byte-lane masks for the G/R/B colour bytes
//     - sequencer state encoding
//     - pixel geometry and counter-width helper
//   No ports (package).
// ----------------------------------------------------------------------------
package layer_pkg;

    // Command bytes, taken from the first byte after chip select falls.
    localparam logic [7:0] CMD_WR_FRAME = 8'hCC;
    localparam logic [7:0] CMD_REFRESH  = 8'hDD;

    // Byte-lane masks. Lane 0 of each 32-bit pixel word is never written.
    localparam logic [3:0] LANE_G = 4'b1000;
    localparam logic [3:0] LANE_R = 4'b0100;
    localparam logic [3:0] LANE_B = 4'b0010;

    // Colour counter values, in wire order G, R, B.
    localparam logic [1:0] COL_G = 2'd0;
    localparam logic [1:0] COL_R = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;

    localparam int PIXELS_PER_LAYER = 64;
    localparam logic [5:0] IDX_MAX  = 6'(PIXELS_PER_LAYER - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } seq_state_e;

    // Layer counter width; a single layer still gets a 1-bit counter.
    function automatic int layer_cnt_w(input int layers);
        return (layers > 1) ? $clog2(layers) : 1;
    endfunction

    // Lane mask for the colour byte currently being written.
    function automatic logic [3:0] lane_mask(input logic [1:0] col);
        case (col)
            COL_G:   return LANE_G;
            COL_R:   return LANE_R;
            default: return LANE_B;
        endcase
    endfunction

endpackage

// File: rtl/pix_addr_cnt.sv
// ----------------------------------------------------------------------------
// pix_addr_cnt
//   Cascaded colour / pixel-index / layer counter that addresses the pixel
//   byte being written. The colour counter runs G,R,B; the index advances
//   after each B; the layer advances when the index wraps 63 -> 0.
//
//   Ports:
//     clk_i, rst_n_i  clock, asynchronous active-low reset
//     clr_i           synchronous clear of all three counters (wins over inc_i)
//     inc_i           advance by one colour byte
//     col_o           colour counter (0=G, 1=R, 2=B)
//     idx_o           pixel index 0..63 within the layer
//     layer_o         layer number 0..LAYERS-1
//     last_o          counters point at the final byte of the frame
// ----------------------------------------------------------------------------
module pix_addr_cnt
    import layer_pkg::*;
#(
    parameter int LAYERS = 8,
    localparam int LW    = layer_cnt_w(LAYERS)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [1:0]    col_o,
    output logic [5:0]    idx_o,
    output logic [LW-1:0] layer_o,
    output logic          last_o
);

    localparam logic [LW-1:0] LAST_LAYER = LW'(LAYERS - 1);

    logic [1:0]    col_q,   col_d;
    logic [5:0]    idx_q,   idx_d;
    logic [LW-1:0] layer_q, layer_d;

    always_comb begin
        col_d   = col_q;
        idx_d   = idx_q;
        layer_d = layer_q;
        if (clr_i) begin
            col_d   = COL_G;
            idx_d   = '0;
            layer_d = '0;
        end else if (inc_i) begin
            if (col_q == COL_B) begin
                col_d = COL_G;
                idx_d = idx_q + 6'd1;
                if (idx_q == IDX_MAX) begin
                    // Explicit wrap keeps the layer inside 0..LAYERS-1 even
                    // when LAYERS does not fill the counter's binary range.
                    layer_d = (layer_q == LAST_LAYER) ? '0 : layer_q + LW'(1);
                end
            end else begin
                col_d = col_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col_q   <= COL_G;
            idx_q   <= '0;
            layer_q <= '0;
        end else begin
            col_q   <= col_d;
            idx_q   <= idx_d;
            layer_q <= layer_d;
        end
    end

    assign col_o   = col_q;
    assign idx_o   = idx_q;
    assign layer_o = layer_q;
    assign last_o  = (col_q == COL_B) && (idx_q == IDX_MAX) && (layer_q == LAST_LAYER);

endmodule

// File: rtl/layer_seq.sv
// ----------------------------------------------------------------------------
// layer_seq
//   Parses the SPI byte stream into commands and routes pixel bytes to the
//   per-layer RAMs (layer, pixel index, byte lane). After a complete frame or
//   a refresh command it emits one shared refresh strobe so all layers start
//   shifting out together.
//
//   Byte interface: spi_byte_rdy_in is a one-cycle strobe qualifying
//   spi_byte_data_in; there is no backpressure, every strobe is consumed in
//   the cycle it is seen, and strobes are at least two cycles apart.
//
//   Ports:
//     clk_in, rst_n_in   clock, asynchronous active-low reset
//     spi_cs_n_in        synchronised chip select, low = transaction active
//     spi_byte_rdy_in    received-byte strobe
//     spi_byte_data_in   received byte
//     layer_en_out       one-hot layer write enable, one cycle per pixel byte
//     data_idx_out       pixel index 0..63 within the current layer
//     byte_sel_out       RAM byte-lane mask of the current byte
//     spi_data_out       pixel byte, valid while layer_en_out is non-zero
//     data_rdy_out       one-cycle refresh strobe to all layers
//     busy_out           high while receiving frame data
// ----------------------------------------------------------------------------
module layer_seq
    import layer_pkg::*;
#(
    parameter int LAYERS = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              spi_cs_n_in,
    input  logic              spi_byte_rdy_in,
    input  logic [7:0]        spi_byte_data_in,
    output logic [LAYERS-1:0] layer_en_out,
    output logic [5:0]        data_idx_out,
    output logic [3:0]        byte_sel_out,
    output logic [7:0]        spi_data_out,
    output logic              data_rdy_out,
    output logic              busy_out
);

    localparam int LW = layer_cnt_w(LAYERS);

    seq_state_e        state_q, state_d;
    logic [LAYERS-1:0] layer_en_q;
    logic [3:0]        byte_sel_q;
    logic [7:0]        spi_data_q;
    logic              data_rdy_q;
    logic              busy_q;
    logic              refresh_pend_q;

    logic              cnt_clr;
    logic              cnt_inc;
    logic [1:0]        cnt_col;
    logic [5:0]        cnt_idx;
    logic [LW-1:0]     cnt_layer;
    logic              cnt_last;

    logic              wr_d;
    logic              refresh_now_d;
    logic              refresh_pend_d;

    // The counter advances in the write cycle itself, so the address outputs
    // describe the byte being written and move on only one cycle later.
    assign cnt_inc = |layer_en_q;

    pix_addr_cnt #(
        .LAYERS (LAYERS)
    ) u_addr (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .col_o   (cnt_col),
        .idx_o   (cnt_idx),
        .layer_o (cnt_layer),
        .last_o  (cnt_last)
    );

    // Next-state and action decode.
    always_comb begin
        state_d        = state_q;
        cnt_clr        = 1'b0;
        wr_d           = 1'b0;
        refresh_now_d  = 1'b0;
        refresh_pend_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!spi_cs_n_in) begin
                    state_d = CMD;
                    cnt_clr = 1'b1;
                end
            end
            CMD: begin
                if (spi_byte_rdy_in) begin
                    if (spi_byte_data_in == CMD_WR_FRAME) begin
                        state_d = DATA;
                    end else begin
                        state_d       = DISCARD;
                        refresh_now_d = (spi_byte_data_in == CMD_REFRESH);
                    end
                end
            end
            DATA: begin
                if (spi_byte_rdy_in) begin
                    wr_d = 1'b1;
                    if (cnt_last) begin
                        // Refresh is held back one cycle so the final write
                        // lands before the layers start reading out.
                        refresh_pend_d = 1'b1;
                        state_d        = DISCARD;
                    end
                end
            end
            DISCARD: begin
                state_d = DISCARD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Chip select high ends the transaction from any state; a byte seen
        // in the same cycle has already been acted on above.
        if (spi_cs_n_in) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= IDLE;
            layer_en_q     <= '0;
            byte_sel_q     <= LANE_G;
            spi_data_q     <= '0;
            data_rdy_q     <= 1'b0;
            busy_q         <= 1'b0;
            refresh_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy_q         <= (state_d == DATA);
            layer_en_q     <= wr_d ? (LAYERS'(1) << cnt_layer) : '0;
            refresh_pend_q <= refresh_pend_d;
            data_rdy_q     <= refresh_now_d | refresh_pend_q;
            if (wr_d) begin
                spi_data_q <= spi_byte_data_in;
                byte_sel_q <= lane_mask(cnt_col);
            end else if (cnt_clr) begin
                byte_sel_q <= LANE_G;
            end
        end
    end

    assign layer_en_out = layer_en_q;
    assign data_idx_out = cnt_idx;
    assign byte_sel_out = byte_sel_q;
    assign spi_data_out = spi_data_q;
    assign data_rdy_out = data_rdy_q;
    assign busy_out     = busy_q;

endmodule
